// File: rtl/ahb2apb_bridge_param.sv
// ---------------------------------------------------------------------------
// ahb2apb_bridge_param
//
// AHB-Lite slave to APB master bridge with a configurable number of equally
// sized APB slave windows. One transfer is outstanding at a time. It supports
// APB wait states, slave errors, decode misses with a two-cycle AHB ERROR
// response, and an optional watchdog on long ACCESS phases.
//
// Parameters:
//   NUM_SLAVES     number of APB slaves and width of Pselx (1..16)
//   BASE_ADDR      start address of slave 0
//   SLAVE_SIZE     window size per slave (power of two)
//   TIMEOUT_CYCLES maximum ACCESS cycles with Pready low; 0 disables
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   Hwrite, Hreadyin, Htrans, Haddr  AHB address phase inputs
//   Hwdata                           AHB write data (data phase)
//   Hreadyout, Hresp, Hrdata         AHB response outputs
//   Pselx, Paddr, Pwdata, Pwrite,    APB master outputs
//   Penable
//   Pready, Pslverr, Prdata          APB slave response inputs
// ---------------------------------------------------------------------------
module ahb2apb_bridge_param #(
    parameter int unsigned NUM_SLAVES     = 3,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter logic [31:0] SLAVE_SIZE     = 32'h0400_0000,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Hwrite,
    input  logic                  Hreadyin,
    input  logic [1:0]            Htrans,
    input  logic [31:0]           Haddr,
    input  logic [31:0]           Hwdata,
    output logic                  Hreadyout,
    output logic [1:0]            Hresp,
    output logic [31:0]           Hrdata,
    output logic [NUM_SLAVES-1:0] Pselx,
    output logic [31:0]           Paddr,
    output logic [31:0]           Pwdata,
    output logic                  Pwrite,
    output logic                  Penable,
    input  logic                  Pready,
    input  logic                  Pslverr,
    input  logic [31:0]           Prdata
);

    localparam int SHIFT = $clog2(SLAVE_SIZE);
    // Wide enough to hold TIMEOUT_CYCLES; the counter saturates at all-ones.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t                state_q,   state_d;
    logic [31:0]           haddr_q,   haddr_d;
    logic                  hwrite_q,  hwrite_d;
    logic [NUM_SLAVES-1:0] sel_q,     sel_d;
    logic [NUM_SLAVES-1:0] pselx_q,   pselx_d;
    logic                  penable_q, penable_d;
    logic [31:0]           paddr_q,   paddr_d;
    logic                  pwrite_q,  pwrite_d;
    logic [31:0]           pwdata_q,  pwdata_d;
    logic [CNT_W-1:0]      tcnt_q,    tcnt_d;

    logic [31:0]           off_s;
    logic [31:0]           idx_s;
    logic                  hit_s;
    logic [NUM_SLAVES-1:0] dec_s;
    logic                  hreadyout_s;
    logic                  valid_s;
    logic                  accept_s;
    logic [CNT_W-1:0]      tcnt_inc_s;
    logic                  timeout_s;

    // Address decode: window index from the offset above BASE_ADDR.
    always_comb begin
        off_s = Haddr - BASE_ADDR;
        idx_s = off_s >> SHIFT;
        hit_s = (Haddr >= BASE_ADDR) && (idx_s < 32'(NUM_SLAVES));
        dec_s = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            dec_s[i] = hit_s && (idx_s == 32'(i));
        end
    end

    // AHB response: ready depends on Pready only in ACCESS; read data is passed
    // through only in a clean read completion cycle.
    always_comb begin
        hreadyout_s = 1'b1;
        Hresp       = 2'b00;
        Hrdata      = 32'd0;
        case (state_q)
            ST_IDLE: begin
                hreadyout_s = 1'b1;
            end
            ST_WDATA, ST_SETUP: begin
                hreadyout_s = 1'b0;
            end
            ST_ACCESS: begin
                hreadyout_s = Pready && !Pslverr;
                if (Pready && !Pslverr && !pwrite_q) begin
                    Hrdata = Prdata;
                end else begin
                    Hrdata = 32'd0;
                end
            end
            ST_ERR1: begin
                hreadyout_s = 1'b0;
                Hresp       = 2'b01;
            end
            ST_ERR2: begin
                hreadyout_s = 1'b1;
                Hresp       = 2'b01;
            end
            default: begin
                hreadyout_s = 1'b1;
            end
        endcase
    end

    assign Hreadyout = hreadyout_s;
    assign valid_s   = Hreadyin && hreadyout_s &&
                       ((Htrans == 2'b10) || (Htrans == 2'b11));

    // Saturating wait-state counter and watchdog trip condition.
    always_comb begin
        if (tcnt_q == {CNT_W{1'b1}}) begin
            tcnt_inc_s = tcnt_q;
        end else begin
            tcnt_inc_s = tcnt_q + CNT_W'(1);
        end
        timeout_s = (TIMEOUT_CYCLES != 0) && (tcnt_inc_s == CNT_W'(TIMEOUT_CYCLES));
    end

    // Next-state logic and next values of all registered APB outputs.
    always_comb begin
        state_d   = state_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        sel_d     = sel_q;
        pselx_d   = '0;
        penable_d = 1'b0;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        tcnt_d    = tcnt_q;
        accept_s  = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                accept_s = valid_s;
                state_d  = ST_IDLE;
            end
            ST_WDATA: begin
                pwdata_d = Hwdata;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (Pready) begin
                    if (Pslverr) begin
                        state_d = ST_ERR1;
                    end else begin
                        // Completion cycle may also accept the next transfer.
                        accept_s = valid_s;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_inc_s;
                    if (timeout_s) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept_s) begin
            haddr_d  = Haddr;
            hwrite_d = Hwrite;
            sel_d    = dec_s;
            if (!hit_s) begin
                state_d = ST_ERR1;
            end else if (Hwrite) begin
                state_d = ST_WDATA;
            end else begin
                state_d = ST_SETUP;
            end
        end else begin
            sel_d = sel_q;
        end

        // APB outputs follow the state being entered so they are registered.
        case (state_d)
            ST_SETUP: begin
                pselx_d  = sel_d;
                paddr_d  = haddr_d;
                pwrite_d = hwrite_d;
            end
            ST_ACCESS: begin
                pselx_d   = sel_q;
                penable_d = 1'b1;
            end
            default: begin
                pselx_d   = '0;
                penable_d = 1'b0;
            end
        endcase

        if ((state_d == ST_ACCESS) && (state_q != ST_ACCESS)) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            haddr_q   <= 32'd0;
            hwrite_q  <= 1'b0;
            sel_q     <= '0;
            pselx_q   <= '0;
            penable_q <= 1'b0;
            paddr_q   <= 32'd0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'd0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            sel_q     <= sel_d;
            pselx_q   <= pselx_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign Pselx   = pselx_q;
    assign Penable = penable_q;
    assign Paddr   = paddr_q;
    assign Pwrite  = pwrite_q;
    assign Pwdata  = pwdata_q;

endmodule
